// File: rtl/dsc_s2b_decoder.sv
// Stochastic-to-binary decoder: counts ones and length of serial bitstream frames
// and hands each closed frame's counts to a single-entry output buffer.
module dsc_s2b_decoder #(
  parameter int SNG_WIDTH  = 8,
  parameter int NUM_INPUTS = 3,
  localparam int OUT_WIDTH = SNG_WIDTH * NUM_INPUTS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sn_in,
  input  logic               sn_last,
  output logic [OUT_WIDTH:0] z_ones,
  output logic [OUT_WIDTH:0] z_len,
  output logic               z_trunc,
  output logic               z_valid,
  input  logic               z_ready,
  output logic               busy,
  output logic               drop,
  output logic               state_dbg
);

  // Handshake: a result transfers on any rising edge where z_valid=1 and
  // z_ready=1; while z_valid=1 and z_ready=0 the buffer contents are frozen.
  // z_valid never drops without a transfer (except on reset).

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [OUT_WIDTH:0] CNT_ONE = {{OUT_WIDTH{1'b0}}, 1'b1};
  localparam logic [OUT_WIDTH:0] MAX_LEN = {1'b1, {OUT_WIDTH{1'b0}}};

  state_t             state;
  logic [OUT_WIDTH:0] ones_cnt;
  logic [OUT_WIDTH:0] len_cnt;
  logic [OUT_WIDTH:0] ones_nxt;
  logic [OUT_WIDTH:0] len_nxt;
  logic               at_max;
  logic               close;
  logic               hit_trunc;
  logic               load;

  always_comb begin
    len_nxt   = len_cnt + CNT_ONE;
    ones_nxt  = ones_cnt + {{OUT_WIDTH{1'b0}}, sn_in};
    at_max    = (len_nxt == MAX_LEN);
    close     = en & (sn_last | at_max);
    // A frame that ends on sn_last exactly at full length is a normal close.
    hit_trunc = ~sn_last & at_max;
    load      = close & (~z_valid | z_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ones_cnt <= '0;
      len_cnt  <= '0;
      z_ones   <= '0;
      z_len    <= '0;
      z_trunc  <= 1'b0;
      z_valid  <= 1'b0;
      busy     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (en) begin
        if (close) begin
          state    <= IDLE;
          busy     <= 1'b0;
          ones_cnt <= '0;
          len_cnt  <= '0;
        end else begin
          state    <= ACCUM;
          busy     <= 1'b1;
          ones_cnt <= ones_nxt;
          len_cnt  <= len_nxt;
        end
      end

      if (load) begin
        z_ones  <= ones_nxt;
        z_len   <= len_nxt;
        z_trunc <= hit_trunc;
        z_valid <= 1'b1;
      end else if (close) begin
        drop <= 1'b1;
      end else if (z_valid && z_ready) begin
        z_valid <= 1'b0;
      end
    end
  end

  assign state_dbg = (state == ACCUM);

endmodule

// File: tb/tb_dsc_s2b_decoder.sv
// Bench for dsc_s2b_decoder: directed scenarios plus random traffic checked
// against a frame-level model (bit queue per frame, result queue for delivery).
module tb_dsc_s2b_decoder;
  localparam int SW   = 2;
  localparam int NI   = 2;
  localparam int OW   = SW * NI;
  localparam int MAXF = 1 << OW;
  localparam int EW   = 2 * (OW + 1) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sn_in;
  logic          sn_last;
  logic [OW:0]   z_ones;
  logic [OW:0]   z_len;
  logic          z_trunc;
  logic          z_valid;
  logic          z_ready;
  logic          busy;
  logic          drop;
  logic          state_dbg;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic          frame_q[$];
  logic [EW-1:0] exp_q[$];
  logic          m_valid;
  logic [EW-1:0] m_buf;
  logic          m_drop;

  dsc_s2b_decoder #(.SNG_WIDTH(SW), .NUM_INPUTS(NI)) dut (
    .clk(clk), .rst(rst), .en(en), .sn_in(sn_in), .sn_last(sn_last),
    .z_ones(z_ones), .z_len(z_len), .z_trunc(z_trunc), .z_valid(z_valid),
    .z_ready(z_ready), .busy(busy), .drop(drop), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack_res(input int ones, input int len, input logic trunc);
    logic [OW:0] o;
    logic [OW:0] l;
    o = ones[OW:0];
    l = len[OW:0];
    return {trunc, l, o};
  endfunction

  task automatic check_outputs();
    check_eq("z_valid", z_valid, m_valid);
    check_eq("busy", busy, frame_q.size() != 0);
    check_eq("state_dbg", state_dbg, frame_q.size() != 0);
    check_eq("drop", drop, m_drop);
    if (m_valid) check_eq("z_buf", {z_trunc, z_len, z_ones}, m_buf);
  endtask

  task automatic step(input logic e, input logic s, input logic l, input logic r);
    logic closed;
    int   ones;
    int   len;
    logic [EW-1:0] res;
    en = e; sn_in = s; sn_last = l; z_ready = r;
    closed = 1'b0;
    res = '0;
    if (m_valid && r) begin
      if (exp_q.size() == 0) check_eq("exp_q_underflow", 1, 0);
      else check_eq("delivered", {z_trunc, z_len, z_ones}, exp_q.pop_front());
    end
    if (e) begin
      frame_q.push_back(s);
      if (l || frame_q.size() == MAXF) begin
        ones = 0;
        foreach (frame_q[i]) ones += int'(frame_q[i]);
        len = frame_q.size();
        res = pack_res(ones, len, !l);
        closed = 1'b1;
        frame_q.delete();
      end
    end
    if (closed) begin
      if (!m_valid || r) begin
        m_buf = res;
        m_valid = 1'b1;
        exp_q.push_back(res);
      end else begin
        m_drop = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input logic e, input logic s, input logic l, input logic r);
    rst = 1'b0; en = e; sn_in = s; sn_last = l; z_ready = r;
    @(posedge clk);
    #1;
    frame_q.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_buf = '0;
    m_drop = 1'b0;
    check_eq("rst_ones", z_ones, 0);
    check_eq("rst_len", z_len, 0);
    check_eq("rst_trunc", z_trunc, 0);
    check_outputs();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; sn_in = 1'b0; sn_last = 1'b0; z_ready = 1'b0;
    m_valid = 1'b0; m_buf = '0; m_drop = 1'b0;
    do_reset(1'b1, 1'b1, 1'b1, 1'b1);

    // basic frame 1,0,1,1
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 1, 1);
    check_eq("basic_ones", z_ones, 3);
    check_eq("basic_len", z_len, 4);
    check_eq("basic_trunc", z_trunc, 0);
    step(0, 0, 0, 1);
    check_eq("basic_valid_clear", z_valid, 0);

    // truncation at full length, then a 17th bit opens a new frame
    for (int i = 0; i < MAXF; i++) step(1, 1, 0, 0);
    check_eq("trunc_ones", z_ones, 16);
    check_eq("trunc_len", z_len, 16);
    check_eq("trunc_flag", z_trunc, 1);
    step(1, 0, 0, 1);
    check_eq("trunc_next_busy", busy, 1);
    step(1, 1, 1, 1);
    step(0, 0, 0, 1);

    // backpressure and drop
    do_reset(0, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    check_eq("bp_ones", z_ones, 2);
    check_eq("bp_len", z_len, 3);
    check_eq("bp_drop", drop, 1);
    step(0, 0, 0, 1);
    check_eq("bp_valid_after_hs", z_valid, 0);
    check_eq("bp_drop_sticky", drop, 1);

    // close coincides with handshake
    do_reset(0, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    check_eq("sim_valid", z_valid, 1);
    check_eq("sim_ones", z_ones, 1);
    check_eq("sim_len", z_len, 1);
    check_eq("sim_drop", drop, 0);
    step(0, 0, 0, 1);

    // en gating with poison on idle cycles
    step(1, 1, 0, 1); step(0, 1, 1, 1); step(1, 0, 0, 1); step(0, 1, 1, 1);
    step(1, 0, 0, 1); step(0, 1, 1, 1); step(1, 1, 0, 1);
    check_eq("gate_no_early", z_valid, 0);
    step(0, 1, 1, 1); step(1, 0, 1, 1);
    check_eq("gate_ones", z_ones, 2);
    check_eq("gate_len", z_len, 5);
    step(0, 0, 0, 1);

    // reset mid-frame with a result pending
    step(1, 1, 1, 0);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    do_reset(1, 1, 1, 1);
    step(1, 0, 0, 1); step(1, 1, 1, 1);
    check_eq("post_rst_ones", z_ones, 1);
    check_eq("post_rst_len", z_len, 2);
    step(0, 0, 0, 1);

    // random traffic: short frames, then long frames that often truncate
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      end else begin
        step($urandom_range(0, 9) < 7, $urandom_range(0, 1),
             (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0),
             $urandom_range(0, 9) < 6);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
